// File: rtl/i2c_cmd_sequencer_if.sv
// Command, I2C-master and response signals of the i2c_cmd_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface i2c_cmd_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_dev_addr;
    logic [7:0]    cmd_inner_addr;
    logic [7:0]    cmd_wdata;
    logic          cmd_rw;
    logic [6:0]    devAddr;
    logic [7:0]    devInnerAddr;
    logic [7:0]    sendData;
    logic          rw;
    logic          go;
    logic          done;
    logic [7:0]    readData;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_rw;
    logic          rsp_timeout;
    logic          busy;
    logic [CW-1:0] queue_count;

    modport slave (
        input  cmd_valid, cmd_dev_addr, cmd_inner_addr, cmd_wdata, cmd_rw,
        input  done, readData, rsp_ready,
        output cmd_ready, devAddr, devInnerAddr, sendData, rw, go,
        output rsp_valid, rsp_data, rsp_rw, rsp_timeout, busy, queue_count
    );

    modport master (
        output cmd_valid, cmd_dev_addr, cmd_inner_addr, cmd_wdata, cmd_rw,
        output done, readData, rsp_ready,
        input  cmd_ready, devAddr, devInnerAddr, sendData, rw, go,
        input  rsp_valid, rsp_data, rsp_rw, rsp_timeout, busy, queue_count
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues register-level I2C transactions, issues them one at a time to the
// I2C master, and returns one response (read data or timeout) per command.
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [6:0] dev_addr;
        logic [7:0] inner_addr;
        logic [7:0] wdata;
        logic       rw;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    cmd_t          cur_q, cur_d;
    logic          done_q;
    logic          go_q, go_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_rw_q, rsp_rw_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          push_c, pop_c, done_rise_c;

    // A done level that was already high before this cycle is not a completion.
    assign push_c      = bus.cmd_valid & cmd_ready_q;
    assign done_rise_c = bus.done & ~done_q;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cur_d         = cur_q;
        go_d          = go_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_rw_d      = rsp_rw_q;
        rsp_timeout_d = rsp_timeout_q;
        pop_c         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    cur_d   = mem_q[rd_ptr_q];
                    go_d    = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (done_rise_c) begin
                    rsp_data_d    = cur_q.rw ? bus.readData : 8'h00;
                    rsp_rw_d      = cur_q.rw;
                    rsp_timeout_d = 1'b0;
                    go_d          = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_data_d    = 8'h00;
                    rsp_rw_d      = cur_q.rw;
                    rsp_timeout_d = 1'b1;
                    go_d          = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // FIFO bookkeeping; ready deliberately ignores a same-cycle pop.
        wr_ptr_d    = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push_c) - CW'(pop_c);
        cmd_ready_d = count_d < CW'(DEPTH);
        busy_d      = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            cur_q         <= '0;
            done_q        <= 1'b0;
            go_q          <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_rw_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cur_q         <= cur_d;
            done_q        <= bus.done;
            go_q          <= go_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rw_q      <= rsp_rw_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Storage needs no reset: only entries behind a valid write pointer are read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_t'{dev_addr:   bus.cmd_dev_addr,
                                      inner_addr: bus.cmd_inner_addr,
                                      wdata:      bus.cmd_wdata,
                                      rw:         bus.cmd_rw};
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.devAddr      = cur_q.dev_addr;
    assign bus.devInnerAddr = cur_q.inner_addr;
    assign bus.sendData     = cur_q.wdata;
    assign bus.rw           = cur_q.rw;
    assign bus.go           = go_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_rw       = rsp_rw_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.busy         = busy_q;
    assign bus.queue_count  = count_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: vector table, directed corner
// sequences, then random traffic against a queue-based transaction model.
module tb_i2c_cmd_sequencer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [6:0] da;
        logic [7:0] ia;
        logic [7:0] wd;
        logic       rw;
    } tcmd_t;

    typedef struct {
        logic        cv;
        tcmd_t       c;
        logic        dn;
        logic [7:0]  rd;
        logic        rr;
        logic [40:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];

    i2c_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();
    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state: pending commands, in-flight command and response.
    tcmd_t      m_q[$];
    tcmd_t      m_cur;
    int         m_phase;
    int         m_age;
    bit         m_ready, m_done_prev, m_rrw, m_rto;
    logic [7:0] m_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input bit cv, input tcmd_t c, input bit dn, input logic [7:0] rd, input bit rr);
        bus.cmd_valid      = cv;
        bus.cmd_dev_addr   = c.da;
        bus.cmd_inner_addr = c.ia;
        bus.cmd_wdata      = c.wd;
        bus.cmd_rw         = c.rw;
        bus.done           = dn;
        bus.readData       = rd;
        bus.rsp_ready      = rr;
    endtask

    function automatic logic [40:0] outs();
        return {bus.cmd_ready, bus.go, bus.devAddr, bus.devInnerAddr, bus.sendData, bus.rw,
                bus.rsp_valid, bus.rsp_data, bus.rsp_rw, bus.rsp_timeout, bus.busy, bus.queue_count};
    endfunction

    function automatic logic [40:0] ev(bit rdy, bit go, tcmd_t f, bit rv, logic [7:0] rdat,
                                       bit rrw, bit rto, bit busy, logic [2:0] qc);
        return {rdy, go, f.da, f.ia, f.wd, f.rw, rv, rdat, rrw, rto, busy, qc};
    endfunction

    task automatic add(input bit cv, input tcmd_t c, input bit dn, input logic [7:0] rd,
                       input bit rr, input logic [40:0] e);
        vec_t v;
        v.cv = cv; v.c = c; v.dn = dn; v.rd = rd; v.rr = rr; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_phase = 0; m_age = 0;
        m_ready = 1'b0; m_done_prev = 1'b0; m_rrw = 1'b0; m_rto = 1'b0; m_rd = 8'h00;
    endtask

    // One clock of transaction-level behaviour (phase 0 idle, 1 in flight, 2 response held).
    task automatic model_step(input bit cv, input tcmd_t c, input bit dn, input logic [7:0] rd, input bit rr);
        bit take = cv && m_ready;
        bit rise = dn && !m_done_prev;
        if (m_phase == 2) begin
            if (rr) m_phase = 0;
        end else if (m_phase == 1) begin
            m_age++;
            if (rise) begin
                m_phase = 2; m_rd = m_cur.rw ? rd : 8'h00; m_rrw = m_cur.rw; m_rto = 1'b0;
            end else if (m_age == TIMEOUT) begin
                m_phase = 2; m_rd = 8'h00; m_rrw = m_cur.rw; m_rto = 1'b1;
            end
        end else if (m_q.size() != 0) begin
            m_cur = m_q.pop_front(); m_phase = 1; m_age = 0;
        end
        if (take) m_q.push_back(c);
        m_ready     = m_q.size() < DEPTH;
        m_done_prev = dn;
    endtask

    function automatic logic [40:0] model_outs();
        return ev(m_ready, m_phase == 1, m_cur, m_phase == 2, m_rd, m_rrw, m_rto,
                  (m_phase != 0) || (m_q.size() != 0), 3'(m_q.size()));
    endfunction

    task automatic wait_go(input string name);
        for (int n = 0; n < 8 && !bus.go; n++) step();
        check(name, 64'(bus.go), 64'd1);
    endtask

    initial begin
        tcmd_t cz, cw, cr, cc, cx;
        cz = '0;
        cw = {7'h50, 8'h10, 8'hA5, 1'b0};
        cr = {7'h50, 8'h10, 8'h00, 1'b1};
        cc = {7'h22, 8'h33, 8'h44, 1'b0};

        rst = 1'b0;
        drive(0, cz, 0, 8'h00, 0);
        step();
        check("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b1;
        step();
        check("post_reset", 64'(outs()), 64'(ev(1, 0, cz, 0, 8'h00, 0, 0, 0, 3'd0)));

        // Single write, read with held response, command queued during RESP.
        add(1, cw, 0, 8'h00, 0, ev(1, 0, cz, 0, 8'h00, 0, 0, 1, 3'd1));
        for (int i = 0; i < 10; i++) add(0, cz, 0, 8'h00, 0, ev(1, 1, cw, 0, 8'h00, 0, 0, 1, 3'd0));
        add(0, cz, 1, 8'h00, 0, ev(1, 0, cw, 1, 8'h00, 0, 0, 1, 3'd0));
        add(0, cz, 0, 8'h00, 0, ev(1, 0, cw, 1, 8'h00, 0, 0, 1, 3'd0));
        add(0, cz, 0, 8'h00, 1, ev(1, 0, cw, 0, 8'h00, 0, 0, 0, 3'd0));
        add(1, cr, 0, 8'hFF, 0, ev(1, 0, cw, 0, 8'h00, 0, 0, 1, 3'd1));
        for (int i = 0; i < 3; i++) add(0, cz, 0, 8'hFF, 0, ev(1, 1, cr, 0, 8'h00, 0, 0, 1, 3'd0));
        add(0, cz, 1, 8'h3C, 0, ev(1, 0, cr, 1, 8'h3C, 1, 0, 1, 3'd0));
        add(1, cc, 0, 8'hFF, 0, ev(1, 0, cr, 1, 8'h3C, 1, 0, 1, 3'd1));
        for (int i = 0; i < 4; i++) add(0, cz, 0, 8'hFF, 0, ev(1, 0, cr, 1, 8'h3C, 1, 0, 1, 3'd1));
        add(0, cz, 0, 8'h00, 1, ev(1, 0, cr, 0, 8'h3C, 1, 0, 1, 3'd1));
        add(0, cz, 0, 8'h00, 0, ev(1, 1, cc, 0, 8'h3C, 1, 0, 1, 3'd0));
        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].c, tbl[i].dn, tbl[i].rd, tbl[i].rr);
            step();
            check($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end

        // Timeout: the command issued by the last vector never sees done.
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            drive(0, cz, 0, 8'h77, 0);
            step();
            if (k < int'(TIMEOUT)) check($sformatf("to_wait%0d", k), 64'({bus.go, bus.rsp_valid}), 64'b10);
            else check("to_fire", 64'({bus.go, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data}),
                       64'({1'b0, 1'b1, 1'b1, 8'h00}));
        end
        drive(0, cz, 0, 8'h00, 1); step();
        drive(0, cz, 0, 8'h00, 0);

        // Full FIFO behind a stalled transaction, then drain in order.
        drive(1, {7'h01, 8'h11, 8'h00, 1'b1}, 0, 8'h00, 0); step();
        drive(0, cz, 0, 8'h00, 0);
        wait_go("ff_go0");
        for (int i = 1; i <= 5; i++) begin
            drive(1, {7'(i + 1), 8'h11, 8'h00, 1'b1}, 0, 8'h00, 0);
            step();
        end
        drive(0, cz, 0, 8'h00, 0);
        check("ff_full", 64'({bus.cmd_ready, bus.queue_count}), 64'({1'b0, 3'd4}));
        for (int i = 0; i < 5; i++) begin
            wait_go($sformatf("ff_go%0d", i));
            check($sformatf("ff_addr%0d", i), 64'(bus.devAddr), 64'(i + 1));
            drive(0, cz, 1, 8'(8'hA0 + i), 0); step();
            drive(0, cz, 0, 8'h00, 0);
            check($sformatf("ff_rsp%0d", i), 64'({bus.rsp_valid, bus.rsp_rw, bus.rsp_data}),
                  64'({1'b1, 1'b1, 8'(8'hA0 + i)}));
            drive(0, cz, 0, 8'h00, 1); step();
            drive(0, cz, 0, 8'h00, 0);
        end
        step(); step();
        check("ff_drained", 64'({bus.go, bus.busy, bus.queue_count}), 64'd0);

        // Stale done held high across issue.
        drive(0, cz, 1, 8'h5A, 0); step();
        drive(1, {7'h11, 8'h22, 8'h33, 1'b1}, 1, 8'h5A, 0); step();
        drive(0, cz, 1, 8'h5A, 0);
        wait_go("stale_go");
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stale_hold%0d", k), 64'({bus.go, bus.rsp_valid}), 64'b10);
        end
        drive(0, cz, 0, 8'h5A, 0); step();
        check("stale_low", 64'(bus.rsp_valid), 64'd0);
        drive(0, cz, 1, 8'h5A, 0); step();
        check("stale_rise", 64'({bus.rsp_valid, bus.rsp_data}), 64'({1'b1, 8'h5A}));
        drive(0, cz, 0, 8'h00, 1); step();
        drive(0, cz, 0, 8'h00, 0);

        // Asynchronous reset in WAIT with two commands queued.
        cx = {7'h7F, 8'h01, 8'h02, 1'b0};
        drive(1, cx, 0, 8'h00, 0); step();
        drive(0, cz, 0, 8'h00, 0);
        wait_go("rst_go");
        drive(1, cx, 0, 8'h00, 0); step(); step();
        drive(0, cz, 0, 8'h00, 0);
        check("rst_pre", 64'(bus.queue_count), 64'd2);
        #2 rst = 1'b0;
        #1 check("rst_async", 64'({bus.go, bus.rsp_valid, bus.queue_count, bus.cmd_ready, bus.busy}), 64'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("rst_after", 64'({bus.cmd_ready, bus.go, bus.busy, bus.queue_count}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
        drive(1, cx, 0, 8'h00, 0); step();
        drive(0, cz, 0, 8'h00, 0);
        wait_go("rst_newpush");

        // Random traffic against the model, including one mid-run async reset.
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit         cv, dn, rr;
            tcmd_t      c;
            logic [7:0] rd;
            if (i == 1500) begin
                #2 rst = 1'b0;
                model_reset();
                #1 check("rand_rst", 64'(outs()), 64'(model_outs()));
                step();
                rst = 1'b1;
            end
            cv = 1'($urandom_range(0, 1));
            c  = {7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom)};
            dn = ((i / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
            rd = 8'($urandom);
            rr = ($urandom_range(0, 2) != 0);
            drive(cv, c, dn, rd, rr);
            model_step(cv, c, dn, rd, rr);
            step();
            check($sformatf("rand%0d", i), 64'(outs()), 64'(model_outs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
